// File: rtl/pwm_delayed_gen.sv
// Delayed-start PWM generator driven by HPS PIO controls (enable, duty, period).
// Period and duty are shadowed and reloaded only at period boundaries.
module pwm_delayed_gen #(
  parameter int DELAY_CYCLES = 50000000,
  parameter int PERIOD_W     = 25,
  parameter int DUTY_W       = 8
) (
  input  logic                clk_clk,
  input  logic                reset,
  input  logic                enable_in,
  input  logic [DUTY_W-1:0]   duty_cycle_in,
  input  logic [PERIOD_W-1:0] freq_clk_in,
  output logic                pwm_out,
  output logic                running,
  output logic                period_tick
);

  localparam int PROD_W = PERIOD_W + DUTY_W;
  localparam int DCNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DLAST =
    (DELAY_CYCLES > 0) ? DCNT_W'(DELAY_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] p_q, p_d;
  logic [PERIOD_W-1:0] high_q, high_d;

  logic [PERIOD_W-1:0] p_live;
  logic [PERIOD_W-1:0] h_live;
  logic [PROD_W-1:0]   prod;
  logic                last_cyc;
  logic                run_d, pwm_d, tick_d;

  // Periods of 0 or 1 cycles cannot hold both a high and a low phase.
  assign p_live   = (freq_clk_in < PERIOD_W'(2)) ? PERIOD_W'(2) : freq_clk_in;
  assign prod     = {{DUTY_W{1'b0}}, p_live} * {{PERIOD_W{1'b0}}, duty_cycle_in};
  assign h_live   = (&duty_cycle_in) ? p_live : prod[PROD_W-1:DUTY_W];
  assign last_cyc = (cnt_q == p_q - PERIOD_W'(1));

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    high_d  = high_q;
    case (state_q)
      S_IDLE: begin
        if (enable_in) begin
          if (DELAY_CYCLES == 0) begin
            state_d = S_RUN;
            cnt_d   = '0;
            p_d     = p_live;
            high_d  = h_live;
          end else begin
            state_d = S_DELAY;
            dcnt_d  = '0;
          end
        end
      end
      S_DELAY: begin
        if (!enable_in) begin
          state_d = S_IDLE;
        end else if (dcnt_q == DLAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          p_d     = p_live;
          high_d  = h_live;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      S_RUN: begin
        if (!enable_in) begin
          state_d = S_IDLE;
        end else if (last_cyc) begin
          cnt_d  = '0;
          p_d    = p_live;
          high_d = h_live;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registers line up with cnt.
  assign run_d  = (state_d == S_RUN);
  assign pwm_d  = run_d && (cnt_d < high_d);
  assign tick_d = run_d && (cnt_d == p_d - PERIOD_W'(1));

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      high_q      <= '0;
      pwm_out     <= 1'b0;
      running     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      high_q      <= high_d;
      pwm_out     <= pwm_d;
      running     <= run_d;
      period_tick <= tick_d;
    end
  end

endmodule
